mm_host_loader: RTL
===================

# mm_host_loader

Host-side companion of the FIOS Montgomery multiplier core.
- Drives the second port of the dual-port bridge BRAM: accepts operand sections on a valid/ready input stream, writes them at the addresses the core's loader reads from, then pulses the core's start.
- After the core's done, reads the result sections back from the BRAM and presents them on a valid/ready output stream, least-significant section first.

## Interface
Parameters:
- `s`, 8, number of 17-bit sections per operand; must match the core.
- `RES_BASE`, s+1, BRAM word address of result section 0; must match the core's result write region.

Ports:
- `clock_i` in 1: the single clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `s_data_i` in 17: input operand word.
- `s_valid_i` in 1: input word valid.
- `s_ready_o` out 1: input word accepted when `s_valid_i && s_ready_o`.
- `m_data_o` out 17: result section.
- `m_valid_o` out 1: result section valid.
- `m_ready_i` in 1: result section consumed when `m_valid_o && m_ready_i`.
- `core_start_o` out 1: one-cycle start pulse to the core.
- `core_done_i` in 1: core done pulse.
- `BRAM_addr_o` out 32: port-B word address, zero-extended.
- `BRAM_din_o` out 17: port-B write data.
- `BRAM_dout_i` in 17: port-B read data, valid one cycle after `BRAM_en_o`.
- `BRAM_we_o` out 1: port-B write enable.
- `BRAM_en_o` out 1: port-B enable.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse on the last result handshake.

## Operation
- Input word order, 3s+1 words in total:
  - p_prime_0;
  - p[0..s-1];
  - a[0..s-1];
  - b[0..s-1].
- Word k is written to BRAM address k, for k = 0..3s.
- FSM states are IDLE, LOAD, START, WAIT, RD_ISSUE, RD_WAIT, OUT.
- **IDLE:** `s_ready_o`=1. A handshake writes word 0 and moves to LOAD with the word counter at 1.
- **LOAD:** `s_ready_o`=1. Each handshake asserts `BRAM_en_o`=`BRAM_we_o`=1 in the same cycle, with addr = counter and din = `s_data_i`, then increments the counter. The handshake of word 3s moves to START.
- **START:** `core_start_o`=1 for exactly one cycle, then WAIT.
- **WAIT:** waits for `core_done_i`, then RD_ISSUE with the result counter r=0.
- **RD_ISSUE:** `BRAM_en_o`=1, `BRAM_we_o`=0, addr = `RES_BASE`+r.
- **RD_WAIT:** `BRAM_dout_i` is registered into `m_data_o`.
- **OUT:** `m_valid_o`=1, holding `m_data_o` stable until `m_ready_i`.
  - On handshake with r<s-1: r++ and go to RD_ISSUE.
  - On handshake with r=s-1: pulse `done_o` and go to IDLE.
- `s_ready_o`=0 in START, WAIT and all read states; input words are not accepted there.
- `core_done_i` outside WAIT is ignored.
- A `core_done_i` in the START cycle is ignored.
- Counters are sized $clog2(3s+1) and $clog2(s), with no wrap beyond their terminal value.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counters 0, `m_data_o`=0.
- Reset mid-operation aborts immediately. No start pulse, BRAM access or output word is issued after reset asserts. Partially loaded BRAM contents are don't-care.
- Load takes one cycle per accepted word, with zero-bubble back-to-back handshakes.
- `core_start_o` is asserted the cycle after the word-3s handshake.
- First `m_valid_o` rises 3 cycles after the `core_done_i` cycle.
- With `m_ready_i` held high, one result word is produced per 3 cycles.
- `BRAM_en_o` is never high in WAIT, START or OUT.
- No BRAM read overlaps a write.

## Configuration
- Macro `MM_HOST_LOADER_CYCLE_COUNT_EN`.
- **Defined:** adds output port `cycles_o` (32 bits), a counter with these rules:
  - cleared to 0 in the START cycle;
  - increments each WAIT cycle;
  - saturates at 2^32-1;
  - holds its value until the next START;
  - reset value 0.
- **Undefined:** the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `mm_host_pkg` holds:
  - the FSM state enum `mm_host_state_t`;
  - `WORD_W`=17;
  - `BRAM_ADDR_W`=32.
- The result read-out path (RD_ISSUE/RD_WAIT/OUT with the output register) is a natural sub-module, `mm_res_reader`. It has its own start/`done_o`, `BRAM_en`/addr request and stream handshake, and the top FSM hands off to it from WAIT.

## Test plan
- **Load, s=4:** stream 13 words 0x00001..0x0000D with `s_valid_i` held high.
  - Expect 13 consecutive writes at addr 0..12 with matching din.
  - Expect `core_start_o` one cycle after the 13th handshake, and `s_ready_o`=0 afterwards.
- **Readback:** BRAM model holds 0x1AAAA, 0x15555, 0x00001, 0x1FFFF at 5..8. Pulse `core_done_i`.
  - Expect reads at addr 5..8.
  - Expect `m_data_o` to carry those four values in order.
  - Expect `done_o` on the 4th handshake, then IDLE.
- **Backpressure:** hold `m_ready_i`=0 for 10 cycles on word 2.
  - `m_data_o`/`m_valid_o` stay stable.
  - No extra BRAM reads occur.
- **Input bubbles:** toggle `s_valid_i` every cycle.
  - Only handshake cycles produce writes; addresses stay contiguous.
- **Reset mid-WAIT:** assert `reset_i` asynchronously between clock edges.
  - All outputs go to 0 at once.
  - A later `core_done_i` produces no reads.
- **Cycle count (`MM_HOST_LOADER_CYCLE_COUNT_EN` defined):** `core_done_i` arrives 100 cycles into WAIT.
  - Expect `cycles_o`=100, held until the next START.

Source files
------------

// File: rtl/mm_host_pkg.sv
// Shared types for the Montgomery-core host loader: FSM states, word/address widths
// and the read request handed from the result reader to the BRAM port mux.
package mm_host_pkg;
    localparam int WORD_W      = 17;
    localparam int BRAM_ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        RD_ISSUE,
        RD_WAIT,
        OUT
    } mm_host_state_t;

    typedef struct packed {
        logic                   en;
        logic [BRAM_ADDR_W-1:0] addr;
    } bram_rd_req_t;
endpackage

// File: rtl/mm_res_reader.sv
// Result read-out: fetches s result sections from the BRAM, one per 3 cycles,
// and presents each on a valid/ready stream, least-significant first.
module mm_res_reader
    import mm_host_pkg::*;
#(
    parameter int s        = 8,
    parameter int RES_BASE = s + 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    output bram_rd_req_t      req_o,
    input  logic [WORD_W-1:0] dout_i,
    output logic [WORD_W-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              done_o
);
    localparam int RW = (s > 1) ? $clog2(s) : 1;

    mm_host_state_t         state;
    logic [RW-1:0]          r;
    logic                   rd_en;
    logic [BRAM_ADDR_W-1:0] rd_addr;
    logic                   last;

    assign last   = (r == RW'(s - 1));
    assign done_o = (state == OUT) && m_ready_i && last;

    always_comb begin
        req_o      = '0;
        req_o.en   = rd_en;
        req_o.addr = rd_addr;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            r         <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            m_data_o  <= '0;
            m_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    state   <= RD_ISSUE;
                    r       <= '0;
                    rd_en   <= 1'b1;
                    rd_addr <= BRAM_ADDR_W'(RES_BASE);
                end
                RD_ISSUE: begin
                    state <= RD_WAIT;
                    rd_en <= 1'b0;
                end
                RD_WAIT: begin
                    m_data_o  <= dout_i;
                    m_valid_o <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (m_ready_i) begin
                    m_valid_o <= 1'b0;
                    if (last) begin
                        state <= IDLE;
                    end else begin
                        r       <= r + 1'b1;
                        state   <= RD_ISSUE;
                        rd_en   <= 1'b1;
                        rd_addr <= BRAM_ADDR_W'(RES_BASE) + BRAM_ADDR_W'(r) + 1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/mm_host_loader.sv
// Host-side loader for the FIOS Montgomery core: streams operands into BRAM port B,
// starts the core, then streams the result back. Option: MM_HOST_LOADER_CYCLE_COUNT_EN.
module mm_host_loader
    import mm_host_pkg::*;
#(
    parameter int s        = 8,
    parameter int RES_BASE = s + 1
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic [WORD_W-1:0]      s_data_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    output logic [WORD_W-1:0]      m_data_o,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic                   core_start_o,
    input  logic                   core_done_i,
    output logic [BRAM_ADDR_W-1:0] BRAM_addr_o,
    output logic [WORD_W-1:0]      BRAM_din_o,
    input  logic [WORD_W-1:0]      BRAM_dout_i,
    output logic                   BRAM_we_o,
    output logic                   BRAM_en_o,
    output logic                   busy_o,
    output logic                   done_o
`ifdef MM_HOST_LOADER_CYCLE_COUNT_EN
    ,
    output logic [31:0]            cycles_o
`endif
);
    localparam int             CW        = $clog2(3 * s + 1);
    localparam logic [CW-1:0]  LAST_WORD = CW'(3 * s);

    mm_host_state_t state;
    logic [CW-1:0]  cnt;
    logic           ready_q;
    logic           start_q;
    logic           s_hs;
    logic           rd_start;
    logic           rd_done;
    bram_rd_req_t   rd_req;

    assign s_ready_o    = ready_q;
    assign s_hs         = s_valid_i && ready_q;
    assign rd_start     = (state == WAIT) && core_done_i;
    assign core_start_o = start_q;
    assign busy_o       = (state != IDLE);
    assign done_o       = rd_done;

    // Writes only happen while loading and reads only while the reader runs,
    // so the two never contend for port B.
    always_comb begin
        BRAM_en_o   = s_hs | rd_req.en;
        BRAM_we_o   = s_hs;
        BRAM_addr_o = '0;
        BRAM_din_o  = '0;
        if (s_hs) begin
            BRAM_addr_o = BRAM_ADDR_W'(cnt);
            BRAM_din_o  = s_data_i;
        end else if (rd_req.en) begin
            BRAM_addr_o = rd_req.addr;
        end
    end

    // The top parks in RD_ISSUE while the reader walks RD_ISSUE/RD_WAIT/OUT itself.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= IDLE;
            cnt     <= '0;
            ready_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (s_hs) begin
                        cnt   <= CW'(1);
                        state <= LOAD;
                    end
                end
                LOAD: if (s_hs) begin
                    if (cnt == LAST_WORD) begin
                        cnt     <= '0;
                        state   <= START;
                        start_q <= 1'b1;
                        ready_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                START: begin
                    start_q <= 1'b0;
                    state   <= WAIT;
                end
                WAIT: if (core_done_i) state <= RD_ISSUE;
                RD_ISSUE: if (rd_done) begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MM_HOST_LOADER_CYCLE_COUNT_EN
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cycles_o <= '0;
        end else if ((state == LOAD && s_hs && cnt == LAST_WORD) || state == START) begin
            cycles_o <= '0;
        end else if (state == WAIT && cycles_o != 32'hFFFF_FFFF) begin
            cycles_o <= cycles_o + 1'b1;
        end
    end
`endif

    mm_res_reader #(
        .s        (s),
        .RES_BASE (RES_BASE)
    ) u_reader (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .start_i   (rd_start),
        .req_o     (rd_req),
        .dout_i    (BRAM_dout_i),
        .m_data_o  (m_data_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .done_o    (rd_done)
    );
endmodule
